// File: rtl/switch_debounce.sv
// Conditions raw board switches: two-flop synchroniser, then an independent
// counting debouncer per channel with registered rise/fall pulses.
module switch_debounce #(
  parameter int NUM_CH          = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] clean_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;
  logic [NUM_CH-1:0] r_clean;
  logic [NUM_CH-1:0] r_rise;
  logic [NUM_CH-1:0] r_fall;
  logic [CNT_W-1:0]  r_count [NUM_CH];

  logic [NUM_CH-1:0] w_clean_nxt;
  logic [NUM_CH-1:0] w_rise_nxt;
  logic [NUM_CH-1:0] w_fall_nxt;
  logic [CNT_W-1:0]  w_count_nxt [NUM_CH];

  // A mismatch must persist for DEBOUNCE_CYCLES consecutive edges; any match restarts it.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_clean_nxt = r_clean;
    w_rise_nxt  = '0;
    w_fall_nxt  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_count_nxt[i] = '0;
      if (r_sync2[i] != r_clean[i]) begin
        if (r_count[i] == CNT_LAST) begin
          w_clean_nxt[i] = r_sync2[i];
          w_rise_nxt[i]  = r_sync2[i];
          w_fall_nxt[i]  = ~r_sync2[i];
        end else begin
          w_count_nxt[i] = r_count[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_clean <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      // NOTE: the counters are plain flops, not a RAM, so they clear with everything else.
      for (int i = 0; i < NUM_CH; i++) begin
        r_count[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking so sync1 -> sync2 forms a true two-stage chain.
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
      r_clean <= w_clean_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        r_count[i] <= w_count_nxt[i];
      end
    end
  end

  assign clean_out  = r_clean;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;

endmodule
